// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter and the receiver:
// default bit timing, data width and the frame state encoding.
package uart_pkg;

  localparam int UART_CLKS_PER_BIT = 868;
  localparam int UART_DATA_W       = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the
// last cycle of each bit period with a one-cycle tick.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = uart_pkg::UART_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int                CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_tick = i_en && !i_clr && (r_cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: accepts a byte over valid/ready and serializes it as
// start bit, 8 data bits LSB first, then STOP_BITS stop bits.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int STOP_BITS    = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tx_valid,
  input  logic [UART_DATA_W-1:0] tx_data,
  output logic                   tx_ready,
  output logic                   uart_txd,
  output logic                   tx_busy,
  output logic                   tx_done
);

  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  uart_state_e            r_state;
  logic [UART_DATA_W-1:0] r_shift;
  logic [2:0]             r_bit_idx;
  logic                   r_stop_cnt;
  logic                   r_txd;
  logic                   r_busy;
  logic                   r_done;

  logic w_tick;
  logic w_baud_clr;
  logic w_baud_en;

  assign w_baud_clr = (r_state == ST_IDLE);
  assign w_baud_en  = !w_baud_clr;

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_cnt (
    .clk   (clk),
    .rst_n (rst),
    .i_en  (w_baud_en),
    .i_clr (w_baud_clr),
    .o_tick(w_tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_bit_idx  <= '0;
      r_stop_cnt <= 1'b0;
      r_txd      <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (tx_valid) begin
            r_shift    <= tx_data;
            r_bit_idx  <= '0;
            r_stop_cnt <= 1'b0;
            r_txd      <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= ST_START;
          end
        end
        ST_START: begin
          if (w_tick) begin
            r_txd   <= r_shift[0];
            r_shift <= r_shift >> 1;
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            if (r_bit_idx == 3'd7) begin
              r_txd   <= 1'b1;
              r_state <= ST_STOP;
            end else begin
              r_txd     <= r_shift[0];
              r_shift   <= r_shift >> 1;
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end
        end
        ST_STOP: begin
          // The line already sits high; only the stop-period count remains.
          if (w_tick) begin
            if (r_stop_cnt == STOP_LAST) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_stop_cnt <= r_stop_cnt + 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign tx_ready = (r_state == ST_IDLE);
  assign uart_txd = r_txd;
  assign tx_busy  = r_busy;
  assign tx_done  = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: random bytes are checked against a
// cycle-level frame model and a mid-bit sampling receiver model.
`timescale 1ns/1ps
module tb_uart_tx;

  localparam int C = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       v0 = 1'b0, v1 = 1'b0, vs = 1'b0;
  logic [7:0] d0 = '0, d1 = '0, ds = '0;
  logic       rdy0, txd0, busy0, done0;
  logic       rdy1, txd1, busy1, done1;
  logic       rdys, txds, busys, dones;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(C), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst(rst), .tx_valid(v0), .tx_data(d0),
    .tx_ready(rdy0), .uart_txd(txd0), .tx_busy(busy0), .tx_done(done0));

  uart_tx #(.CLKS_PER_BIT(C), .STOP_BITS(2)) dut1 (
    .clk(clk), .rst(rst), .tx_valid(v1), .tx_data(d1),
    .tx_ready(rdy1), .uart_txd(txd1), .tx_busy(busy1), .tx_done(done1));

  uart_tx #(.CLKS_PER_BIT(868), .STOP_BITS(1)) dut_slow (
    .clk(clk), .rst(rst), .tx_valid(vs), .tx_data(ds),
    .tx_ready(rdys), .uart_txd(txds), .tx_busy(busys), .tx_done(dones));

  // {ready, txd, busy, done} of the selected 16-clock instance
  function automatic logic [3:0] outs(input int u);
    return (u == 0) ? {rdy0, txd0, busy0, done0} : {rdy1, txd1, busy1, done1};
  endfunction

  task automatic drive(input int u, input logic v, input logic [7:0] d);
    if (u == 0) begin v0 = v; d0 = d; end
    else        begin v1 = v; d1 = d; end
  endtask

  // Called on a negedge; returns on the negedge right after the acceptance edge.
  task automatic accept(input int u, input logic [7:0] b, input int max_wait,
                        output int waited, output bit ok);
    logic [3:0] o;
    drive(u, 1'b1, b);
    ok = 1'b0;
    waited = 0;
    while (!ok && waited <= max_wait) begin
      o = outs(u);
      if (o[3] === 1'b1) begin
        @(posedge clk);
        @(negedge clk);
        ok = 1'b1;
      end else begin
        @(negedge clk);
        waited++;
      end
    end
    n_total++;
    if (ok !== 1'b1) $display("FAIL accept_%0d: byte 0x%02h not accepted within %0d cycles", u, b, max_wait);
    else n_pass++;
  endtask

  // Watches one frame from the first cycle after acceptance (t=0) to IDLE
  // re-entry (t=L) and checks it against the frame model.
  task automatic run_frame(input int u, input logic [7:0] b, input logic new_v,
                           input logic [7:0] new_d, input string name);
    int         s_bits = (u == 0) ? 1 : 2;
    int         len    = (9 + s_bits) * C;
    logic       line[$];
    int         wave_err = 0;
    int         hs_err   = 0;
    int         done_at  = -1;
    int         stop_len = 0;
    logic [7:0] rx;
    logic [3:0] o;
    logic       exp_txd;
    logic       framing;
    drive(u, new_v, new_d);
    for (int t = 0; t <= len; t++) begin
      o = outs(u);
      line.push_back(o[2]);
      if (t < C)          exp_txd = 1'b0;
      else if (t < 9 * C) exp_txd = b[t / C - 1];
      else                exp_txd = 1'b1;
      if (o[2] !== exp_txd) wave_err++;
      if (t < len) begin
        if (o[3] !== 1'b0 || o[1] !== 1'b1) hs_err++;
      end else begin
        if (o[3] !== 1'b1 || o[1] !== 1'b0) hs_err++;
      end
      if (o[0] === 1'b1 && done_at < 0) done_at = t;
      if (t < len) @(negedge clk);
    end
    framing = (line[C / 2] === 1'b0);
    for (int n = 0; n < 8; n++) rx[n] = line[(n + 1) * C + C / 2];
    for (int s = 0; s < s_bits; s++)
      if (line[(9 + s) * C + C / 2] !== 1'b1) framing = 1'b0;
    for (int t = 9 * C; t < len && line[t] === 1'b1; t++) stop_len++;

    n_total++;
    if (rx !== b) $display("FAIL %s_rx: decoded 0x%02h, want 0x%02h", name, rx, b);
    else n_pass++;
    n_total++;
    if (framing !== 1'b1) $display("FAIL %s_framing: start/stop samples got %b, want 1", name, framing);
    else n_pass++;
    n_total++;
    if (done_at !== len) $display("FAIL %s_done_at: tx_done at cycle %0d, want %0d", name, done_at, len);
    else n_pass++;
    n_total++;
    if (wave_err !== 0) $display("FAIL %s_wave: %0d txd cycles differ from model, want 0", name, wave_err);
    else n_pass++;
    n_total++;
    if (hs_err !== 0) $display("FAIL %s_ready_busy: %0d cycles wrong, want 0", name, hs_err);
    else n_pass++;
    n_total++;
    if (stop_len !== s_bits * C) $display("FAIL %s_stop_len: stop high %0d cycles, want %0d", name, stop_len, s_bits * C);
    else n_pass++;

    if (new_v === 1'b0) begin
      @(negedge clk);
      o = outs(u);
      n_total++;
      if (o !== 4'b1100) $display("FAIL %s_after: {rdy,txd,busy,done}=%b, want 1100", name, o);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    int bad = 0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_total++;
    if ({rdys, txds, busys, dones} !== 4'b1100)
      $display("FAIL reset_state: {rdy,txd,busy,done}=%b, want 1100", {rdys, txds, busys, dones});
    else n_pass++;
    rst = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (dones !== 1'b0 || txds !== 1'b1 || busys !== 1'b0 || rdys !== 1'b1) bad++;
    end
    n_total++;
    if (bad !== 0) $display("FAIL idle_2000: %0d cycles left idle, want 0", bad);
    else n_pass++;
    for (int u = 0; u < 2; u++) begin
      n_total++;
      if (outs(u) !== 4'b1100) $display("FAIL reset_inst%0d: {rdy,txd,busy,done}=%b, want 1100", u, outs(u));
      else n_pass++;
    end
  endtask

  task automatic test_send_55();
    int w; bit ok;
    accept(0, 8'h55, 400, w, ok);
    if (ok) run_frame(0, 8'h55, 1'b0, 8'hC3, "tx55");
  endtask

  task automatic test_back_to_back();
    int w; bit ok;
    accept(0, 8'hA3, 400, w, ok);
    if (!ok) return;
    run_frame(0, 8'hA3, 1'b1, 8'h0F, "b2b_a3");
    accept(0, 8'h0F, 400, w, ok);
    n_total++;
    if (w !== 0) $display("FAIL b2b_gap: second byte waited %0d cycles in idle, want 0", w);
    else n_pass++;
    if (ok) run_frame(0, 8'h0F, 1'b0, 8'h5A, "b2b_0f");
  endtask

  task automatic test_busy_ignored();
    int w; bit ok;
    accept(0, 8'h00, 400, w, ok);
    if (!ok) return;
    run_frame(0, 8'h00, 1'b1, 8'hFF, "busy_00");
    accept(0, 8'hFF, 400, w, ok);
    n_total++;
    if (w !== 0) $display("FAIL busy_ff_wait: accepted after %0d idle cycles, want 0", w);
    else n_pass++;
    if (ok) run_frame(0, 8'hFF, 1'b0, 8'h00, "busy_ff");
  endtask

  task automatic test_reset_mid_frame();
    int w; bit ok; int bad = 0;
    accept(0, 8'h3C, 400, w, ok);
    if (!ok) return;
    drive(0, 1'b0, 8'hAA);
    repeat (5 * C + C / 2) @(negedge clk);
    n_total++;
    if (busy0 !== 1'b1) $display("FAIL rst_mid_busy: busy=%b before reset, want 1", busy0);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_total++;
    if ({rdy0, txd0, busy0, done0} !== 4'b1100)
      $display("FAIL rst_mid_async: {rdy,txd,busy,done}=%b, want 1100", {rdy0, txd0, busy0, done0});
    else n_pass++;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3 * 10 * C; i++) begin
      @(negedge clk);
      if (txd0 !== 1'b1 || done0 !== 1'b0 || busy0 !== 1'b0) bad++;
    end
    n_total++;
    if (bad !== 0) $display("FAIL rst_mid_quiet: %0d cycles not idle after reset, want 0", bad);
    else n_pass++;
    accept(0, 8'h96, 400, w, ok);
    if (ok) run_frame(0, 8'h96, 1'b0, 8'h00, "rst_resend");
  endtask

  task automatic test_stop2();
    int w; bit ok;
    accept(1, 8'h81, 400, w, ok);
    if (ok) run_frame(1, 8'h81, 1'b0, 8'h7E, "stop2_81");
  endtask

  task automatic test_random();
    int w; bit ok; int u; logic [7:0] b;
    for (int i = 0; i < 8; i++) begin
      u = i % 2;
      b = 8'($urandom);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      accept(u, b, 400, w, ok);
      if (ok) run_frame(u, b, 1'b0, 8'($urandom), $sformatf("rand%0d_u%0d", i, u));
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_send_55();
    test_back_to_back();
    test_busy_ignored();
    test_reset_mid_frame();
    test_stop2();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
